// File: rtl/ldl_count_v2_pkg.sv
// Shared types for the bounded up/down step counter: terminal-action modes
// and the run/stopped state used by the one-shot mode.
package LDL_count_pkg;

  typedef enum logic [1:0] {
    LDL_CNT_WRAP    = 2'd0,
    LDL_CNT_SAT     = 2'd1,
    LDL_CNT_ONESHOT = 2'd2
  } ldl_cnt_mode_e;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } ldl_cnt_state_e;

endpackage

// File: rtl/ldl_count_v2.sv
// Bounded up/down counter with programmable step and inclusive [min,max] window;
// terminal action is wrap, saturate or one-shot stop, all outputs registered.
module ldl_count_v2
  import LDL_count_pkg::*;
#(
  parameter int unsigned       WIDTH   = 8,
  parameter ldl_cnt_mode_e     MODE    = LDL_CNT_WRAP,
  parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] min,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] dout,
  output logic             tc,
  output logic             done
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  ldl_cnt_state_e   state_q, state_d;

  logic [WIDTH:0]   up_sum_s;
  logic [WIDTH:0]   dn_floor_s;
  logic             up_term_s;
  logic             dn_term_s;
  logic             term_s;
  logic [WIDTH-1:0] term_val_s;

  // Terminal detection (one extra bit so sums never alias) and next-state selection.
  always_comb begin
    up_sum_s   = {1'b0, dout_q} + {1'b0, step};
    dn_floor_s = {1'b0, min} + {1'b0, step};
    up_term_s  = (up_sum_s > {1'b0, max});
    dn_term_s  = ({1'b0, dout_q} < dn_floor_s);
    term_s     = dir ? dn_term_s : up_term_s;

    case (MODE)
      LDL_CNT_WRAP:    term_val_s = dir ? max : min;
      LDL_CNT_SAT:     term_val_s = dir ? min : max;
      LDL_CNT_ONESHOT: term_val_s = dir ? min : max;
      default:         term_val_s = dir ? min : max;
    endcase

    dout_d  = dout_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    state_d = state_q;

    if (clr) begin
      dout_d  = dir ? max : min;
      done_d  = 1'b0;
      state_d = RUN;
    end else if (load) begin
      dout_d  = load_val;
      done_d  = 1'b0;
      state_d = RUN;
    end else if (en && (state_q == RUN)) begin
      if (term_s) begin
        dout_d = term_val_s;
        tc_d   = 1'b1;
        if (MODE == LDL_CNT_ONESHOT) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = RUN;
          done_d  = 1'b0;
        end
      end else begin
        dout_d = dir ? (dout_q - step) : (dout_q + step);
      end
    end else begin
      tc_d = 1'b0;
    end
  end

  // State and output registers; reset discards any pending terminal pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q  <= RST_VAL;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      state_q <= RUN;
    end else begin
      dout_q  <= dout_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      state_q <= state_d;
    end
  end

  assign dout = dout_q;
  assign tc   = tc_q;
  assign done = done_q;

endmodule

// File: tb/tb_ldl_count_v2.sv
// Self-checking bench: three counters (WRAP w4, SAT w8, ONESHOT w8) driven by
// directed vector tables, a mid-count async reset, and random stimulus vs a model.
module tb_ldl_count_v2;
  import LDL_count_pkg::*;

  typedef struct packed {
    logic       en;
    logic       clr;
    logic       load;
    logic       dir;
    logic [7:0] lv;
    logic [7:0] step;
    logic [7:0] mn;
    logic [7:0] mx;
  } in_t;

  typedef struct {
    int inst;
    bit en, clr, load, dir;
    int lv, step, mn, mx;
    int e_dout;
    bit e_tc, e_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  in_t  ins [3];

  logic [3:0] dout_w;
  logic [7:0] dout_s, dout_o;
  logic       tc_w, tc_s, tc_o, done_w, done_s, done_o;

  int n_checks = 0;
  int n_errors = 0;

  int m_dout [3];
  bit m_tc   [3];
  bit m_done [3];
  int rst_vals [3] = '{3, 0, 7};
  int bmin [3];
  int bmax [3];
  vec_t tbl [$];

  always #5 clk = ~clk;

  ldl_count_v2 #(.WIDTH(4), .MODE(LDL_CNT_WRAP), .RST_VAL(4'd3)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(ins[0].en), .clr(ins[0].clr), .load(ins[0].load),
    .load_val(ins[0].lv[3:0]), .dir(ins[0].dir), .step(ins[0].step[3:0]),
    .min(ins[0].mn[3:0]), .max(ins[0].mx[3:0]), .dout(dout_w), .tc(tc_w), .done(done_w));

  ldl_count_v2 #(.WIDTH(8), .MODE(LDL_CNT_SAT), .RST_VAL(8'd0)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(ins[1].en), .clr(ins[1].clr), .load(ins[1].load),
    .load_val(ins[1].lv), .dir(ins[1].dir), .step(ins[1].step),
    .min(ins[1].mn), .max(ins[1].mx), .dout(dout_s), .tc(tc_s), .done(done_s));

  ldl_count_v2 #(.WIDTH(8), .MODE(LDL_CNT_ONESHOT), .RST_VAL(8'd7)) u_one (
    .clk(clk), .rst_n(rst_n), .en(ins[2].en), .clr(ins[2].clr), .load(ins[2].load),
    .load_val(ins[2].lv), .dir(ins[2].dir), .step(ins[2].step),
    .min(ins[2].mn), .max(ins[2].mx), .dout(dout_o), .tc(tc_o), .done(done_o));

  function automatic int dut_dout(int i);
    case (i)
      0:       return int'(dout_w);
      1:       return int'(dout_s);
      default: return int'(dout_o);
    endcase
  endfunction

  function automatic int dut_tc(int i);
    case (i)
      0:       return int'(tc_w);
      1:       return int'(tc_s);
      default: return int'(tc_o);
    endcase
  endfunction

  function automatic int dut_done(int i);
    case (i)
      0:       return int'(done_w);
      1:       return int'(done_s);
      default: return int'(done_o);
    endcase
  endfunction

  function automatic vec_t mk(int inst, bit en, bit clr, bit load, bit dir, int lv,
                              int step, int mn, int mx, int e_dout, bit e_tc, bit e_done);
    vec_t v;
    v.inst = inst; v.en = en; v.clr = clr; v.load = load; v.dir = dir;
    v.lv = lv; v.step = step; v.mn = mn; v.mx = mx;
    v.e_dout = e_dout; v.e_tc = e_tc; v.e_done = e_done;
    return v;
  endfunction

  task automatic chk(string name, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) ins[i] = '0;
  endtask

  task automatic set_in(int i, bit en, bit clr, bit load, bit dir, int lv, int step, int mn, int mx);
    ins[i].en   = en;
    ins[i].clr  = clr;
    ins[i].load = load;
    ins[i].dir  = dir;
    ins[i].lv   = lv[7:0];
    ins[i].step = step[7:0];
    ins[i].mn   = mn[7:0];
    ins[i].mx   = mx[7:0];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_dout[i] = rst_vals[i];
      m_tc[i]   = 1'b0;
      m_done[i] = 1'b0;
    end
  endtask

  // Reference: plain integer arithmetic on the counting rules, so no overflow can occur.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int d, s, lo, hi;
      bit term;
      d = m_dout[i]; s = int'(ins[i].step); lo = int'(ins[i].mn); hi = int'(ins[i].mx);
      m_tc[i] = 1'b0;
      if (ins[i].clr) begin
        m_dout[i] = ins[i].dir ? hi : lo;
        m_done[i] = 1'b0;
      end else if (ins[i].load) begin
        m_dout[i] = int'(ins[i].lv);
        m_done[i] = 1'b0;
      end else if (ins[i].en && !m_done[i]) begin
        term = ins[i].dir ? (d < lo + s) : (d + s > hi);
        if (!term) begin
          m_dout[i] = ins[i].dir ? d - s : d + s;
        end else begin
          m_tc[i] = 1'b1;
          if (i == 0) m_dout[i] = ins[i].dir ? hi : lo;
          else        m_dout[i] = ins[i].dir ? lo : hi;
          if (i == 2) m_done[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_model(string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s.dout[%0d]", tag, i), dut_dout(i), m_dout[i]);
      chk($sformatf("%s.tc[%0d]", tag, i), dut_tc(i), int'(m_tc[i]));
      chk($sformatf("%s.done[%0d]", tag, i), dut_done(i), int'(m_done[i]));
    end
  endtask

  task automatic cycle(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_all();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // WRAP w4: step 3 in [2,9]; down-wrap 0->15; collisions; step 0; min>max
    tbl.push_back(mk(0, 0,1,0,0, 0,3,2,9,   2,0,0));
    tbl.push_back(mk(0, 1,0,0,0, 0,3,2,9,   5,0,0));
    tbl.push_back(mk(0, 1,0,0,0, 0,3,2,9,   8,0,0));
    tbl.push_back(mk(0, 1,0,0,0, 0,3,2,9,   2,1,0));
    tbl.push_back(mk(0, 1,0,0,0, 0,3,2,9,   5,0,0));
    tbl.push_back(mk(0, 0,0,0,0, 0,3,2,9,   5,0,0));
    tbl.push_back(mk(0, 0,0,1,1, 1,1,0,15,  1,0,0));
    tbl.push_back(mk(0, 1,0,0,1, 0,1,0,15,  0,0,0));
    tbl.push_back(mk(0, 1,0,0,1, 0,1,0,15, 15,1,0));
    tbl.push_back(mk(0, 1,1,1,1, 6,1,0,15, 15,0,0));
    tbl.push_back(mk(0, 1,1,1,0, 6,1,2,9,   2,0,0));
    tbl.push_back(mk(0, 1,0,1,0, 6,1,2,9,   6,0,0));
    tbl.push_back(mk(0, 1,0,0,0, 0,0,2,9,   6,0,0));
    tbl.push_back(mk(0, 0,0,1,0, 5,1,9,2,   5,0,0));
    tbl.push_back(mk(0, 1,0,0,0, 0,1,9,2,   9,1,0));
    // SAT w8: repeated tc at max, down saturation, 255 overflow guard
    tbl.push_back(mk(1, 0,0,1,0, 198,5,0,200, 198,0,0));
    tbl.push_back(mk(1, 1,0,0,0, 0,5,0,200,   200,1,0));
    tbl.push_back(mk(1, 1,0,0,0, 0,5,0,200,   200,1,0));
    tbl.push_back(mk(1, 1,0,0,0, 0,5,0,200,   200,1,0));
    tbl.push_back(mk(1, 0,0,0,0, 0,5,0,200,   200,0,0));
    tbl.push_back(mk(1, 0,0,1,1, 12,4,10,200, 12,0,0));
    tbl.push_back(mk(1, 1,0,0,1, 0,4,10,200,  10,1,0));
    tbl.push_back(mk(1, 0,0,1,0, 254,5,0,255, 254,0,0));
    tbl.push_back(mk(1, 1,0,0,0, 0,5,0,255,   255,1,0));
    // ONESHOT w8: run to 3, stop, ignore en, reload, stop again
    tbl.push_back(mk(2, 0,1,0,0, 0,1,0,3, 0,0,0));
    tbl.push_back(mk(2, 1,0,0,0, 0,1,0,3, 1,0,0));
    tbl.push_back(mk(2, 1,0,0,0, 0,1,0,3, 2,0,0));
    tbl.push_back(mk(2, 1,0,0,0, 0,1,0,3, 3,0,0));
    tbl.push_back(mk(2, 1,0,0,0, 0,1,0,3, 3,1,1));
    tbl.push_back(mk(2, 1,0,0,0, 0,1,0,3, 3,0,1));
    tbl.push_back(mk(2, 0,0,1,0, 0,1,0,3, 0,0,0));
    tbl.push_back(mk(2, 1,0,0,0, 0,1,0,3, 1,0,0));
    tbl.push_back(mk(2, 1,0,0,0, 0,1,0,3, 2,0,0));
    tbl.push_back(mk(2, 1,0,0,0, 0,1,0,3, 3,0,0));
    tbl.push_back(mk(2, 1,0,0,0, 0,1,0,3, 3,1,1));

    foreach (tbl[k]) begin
      @(negedge clk);
      idle_all();
      set_in(tbl[k].inst, tbl[k].en, tbl[k].clr, tbl[k].load, tbl[k].dir,
             tbl[k].lv, tbl[k].step, tbl[k].mn, tbl[k].mx);
      cycle($sformatf("vec%0d", k));
      chk($sformatf("tbl%0d.dout", k), dut_dout(tbl[k].inst), tbl[k].e_dout);
      chk($sformatf("tbl%0d.tc", k), dut_tc(tbl[k].inst), int'(tbl[k].e_tc));
      chk($sformatf("tbl%0d.done", k), dut_done(tbl[k].inst), int'(tbl[k].e_done));
    end

    // Async reset between edges while a tc is pending and the one-shot is stopped
    @(negedge clk);
    idle_all();
    set_in(0, 0,0,1,0, 15,1,0,15);
    cycle("pre_rst_load");
    @(negedge clk);
    set_in(0, 1,0,0,0, 0,1,0,15);
    cycle("pre_rst_wrap");
    chk("pre_rst.tc_w", int'(tc_w), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.dout_w", int'(dout_w), 3);
    chk("async_rst.dout_s", int'(dout_s), 0);
    chk("async_rst.dout_o", int'(dout_o), 7);
    chk("async_rst.tc_w", int'(tc_w), 0);
    chk("async_rst.done_o", int'(done_o), 0);
    model_reset();
    #1 rst_n = 1'b1;
    cycle("post_rst_first_step");

    // Random phase against the reference model
    for (int i = 0; i < 3; i++) begin
      bmin[i] = 0;
      bmax[i] = (i == 0) ? 15 : 255;
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        int mask, stp, t;
        mask = (i == 0) ? 15 : 255;
        if ($urandom_range(0, 31) == 0) begin
          bmin[i] = int'($urandom) & mask;
          bmax[i] = int'($urandom) & mask;
          if ($urandom_range(0, 3) != 0 && bmin[i] > bmax[i]) begin
            t = bmin[i]; bmin[i] = bmax[i]; bmax[i] = t;
          end
        end
        stp = ($urandom_range(0, 7) == 0) ? (int'($urandom) & mask) : int'($urandom_range(0, 3));
        set_in(i, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 7) == 0) ? ~ins[i].dir : ins[i].dir,
               int'($urandom) & mask, stp, bmin[i], bmax[i]);
      end
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ldl_count_v2.md
LDL_COUNT_V2 -- requirements
Module: LDL_count_v2

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter/bound/step width in bits (>=1).
REQ-002 SHALL have parameter MODE, default LDL_CNT_WRAP, terminal action: WRAP, SAT (saturate) or ONESHOT.
REQ-003 SHALL have parameter RST_VAL, default 0, value of dout after reset.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port en  input  1  step enable.
REQ-007 SHALL have port clr  input  1  synchronous clear to start value.
REQ-008 SHALL have port load  input  1  synchronous load of load_val.
REQ-009 SHALL have port load_val  input  WIDTH  load value.
REQ-010 SHALL have port dir  input  1  0 = count up, 1 = count down.
REQ-011 SHALL have port step  input  WIDTH  increment/decrement magnitude.
REQ-012 SHALL have port min, max  input  WIDTH each  inclusive bounds, unsigned.
REQ-013 SHALL have port dout  output  WIDTH  registered count.
REQ-014 SHALL have port tc  output  1  registered terminal-count pulse.
REQ-015 SHALL have port done  output  1  registered, ONESHOT stopped flag (constant 0 in other modes).

Function
REQ-016 Priority each cycle SHALL be clr > load > en; none asserted -> all state held, tc = 0.
REQ-017 clr SHALL set dout = min (dir=0) or max (dir=1), tc = 0, done = 0, state RUN.
REQ-018 load SHALL set dout = load_val unchecked against bounds, tc = 0, done = 0, state RUN.
REQ-019 Up terminal SHALL be (dout + step) > max, evaluated in WIDTH+1 bits (no overflow alias).
REQ-020 Down terminal SHALL be dout < (min + step), evaluated in WIDTH+1 bits.
REQ-021 Non-terminal en step SHALL give dout +/- step, 1-cycle latency, tc = 0.
REQ-022 Terminal en step, WRAP: up -> dout = min, down -> dout = max; no remainder carried.
REQ-023 Terminal en step, SAT: up -> dout = max, down -> dout = min; repeated en at the bound re-pulses tc.
REQ-024 Terminal en step, ONESHOT: as SAT, state RUN -> DONE, done = 1.
REQ-025 tc SHALL be high exactly in the cycle after a terminal en step, i.e. with dout's terminal value.
REQ-026 ONESHOT state DONE SHALL ignore en (dout held, tc = 0) until clr or load returns it to RUN.
REQ-027 step = 0 SHALL hold dout; tc only if dout already out of range, per REQ-019/020.
REQ-028 min > max SHALL be legal, unchecked; behaviour follows REQ-019..024 literally.
REQ-029 dir or bounds changing mid-count SHALL take effect on the next en step with no extra latency.

Reset
REQ-030 rst_n low SHALL asynchronously set dout = RST_VAL, tc = 0, done = 0, state RUN.
REQ-031 Reset release SHALL be synchronous; first step occurs on the first edge with rst_n high and en high.
REQ-032 Reset mid-count or in DONE SHALL discard all progress; no pending tc survives.

Structure
REQ-033 Package LDL_count_pkg SHALL hold the mode enum (LDL_CNT_WRAP, LDL_CNT_SAT, LDL_CNT_ONESHOT) and state enum (RUN, DONE).
REQ-034 Terminal detection and next-value arithmetic SHALL be one combinational block in the module; no sub-module.
REQ-035 Outputs SHALL be driven only from flops.

Verification
REQ-036 WRAP, WIDTH=4, min=2, max=9, step=3, up, clr then 4 en -> dout 2,5,8,2,5; tc high only with the second 2.
REQ-037 WRAP, WIDTH=4, min=0, max=15, step=1, down from load 1 -> dout 0 then 15; tc with 15; no overflow alias.
REQ-038 SAT, WIDTH=8, max=200, load 198, step=5, en x3 -> dout 200,200,200; tc high each of the 3 cycles.
REQ-039 ONESHOT, min=0, max=3, step=1, up -> 1,2,3 then done=1, tc once, further en holds 3; load 0 -> done=0, counting resumes.
REQ-040 clr, load and en asserted together -> dout = min/max per dir; load+en -> dout = load_val.
REQ-041 rst_n pulsed low between edges mid-count -> dout = RST_VAL immediately, tc = 0, done = 0.
